halftone_level_quantizer: RTL and testbench
===========================================

# halftone_level_quantizer

Parametrised, pipelined grey-level quantizer for the halftone path. It maps each incoming pixel intensity to a dot-size level by counting how many programmable thresholds the intensity exceeds. Thresholds are written into shadow registers at any time and committed to the active set only on a commit pulse, normally at frame start, so a frame is never quantized with a mix of old and new thresholds. It feeds the dot renderer and replaces the fixed two-threshold size selector.

## Interface
- IN_W, 11, pixel intensity width
- NUM_THRESH, 2, number of thresholds, range 1..7
- LW, 2, output level width; requires MIN_LEVEL+NUM_THRESH <= 2^LW-1
- MIN_LEVEL, 1, level reported when no threshold is exceeded
- AW, 3, threshold address width; requires 2^AW >= NUM_THRESH
- THRESH_INIT, {11'd1300, 11'd700}, packed NUM_THRESH*IN_W reset values; entry k is at [k*IN_W +: IN_W]

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  g is a valid pixel this cycle
- g  in  IN_W  pixel intensity, unsigned
- invert  in  1  per-pixel mode: 0 = bright gives a large level, 1 = bright gives a small level
- out_valid  out  1  level is valid this cycle
- level  out  LW  quantized dot-size level
- thr_we  in  1  write strobe for the shadow threshold
- thr_addr  in  AW  threshold index for write and read-back
- thr_wdata  in  IN_W  threshold value to write
- thr_rdata  out  IN_W  shadow threshold at thr_addr, registered
- commit  in  1  copy all shadow thresholds to the active set

## Operation
- **State.** Two register arrays of NUM_THRESH entries each:
  - shadow[k], written by thr_we;
  - active[k], used for comparison.
- **Reset.** Asynchronous reset forces:
  - shadow[k] and active[k] to THRESH_INIT entry k;
  - both pipeline valid bits to 0;
  - level to 0 and thr_rdata to 0.
- **Write.**
  - thr_we=1 with thr_addr < NUM_THRESH: shadow[thr_addr] <= thr_wdata.
  - thr_addr >= NUM_THRESH: the write is ignored.
- **Read-back.** thr_rdata <= shadow[thr_addr] every cycle; 0 if thr_addr >= NUM_THRESH.
- **Commit.** commit=1: active[k] <= shadow[k] for all k.
  - A write in the same cycle as commit updates shadow but is not copied; it takes effect at the next commit.
- **Stage 1.** Stage 1 registers the following, then clears its valid bit when in_valid=0:
  - v1 <= in_valid;
  - inv1 <= invert;
  - gt1[k] <= (g > active[k]), a strict unsigned compare.
- **Stage 2.** With cnt = popcount(gt1), which lies in 0..NUM_THRESH:
  - level <= MIN_LEVEL + cnt when inv1=0;
  - level <= MIN_LEVEL + NUM_THRESH - cnt when inv1=1.
  - out_valid <= v1.
- **Ordering and width.**
  - Threshold order is irrelevant; there is no monotonic requirement, and duplicate thresholds count twice.
  - The sum is computed at LW bits; the parameter constraint guarantees no overflow.
- **Hold.** When v1=0, level holds its previous value; out_valid=0.
- There is no backpressure. One pixel per cycle is accepted unconditionally.

## Timing
- Latency is 2 cycles: in_valid/g at edge n gives out_valid/level after edge n+2.
- Full throughput: back-to-back valid pixels produce back-to-back outputs in order.
- Thresholds:
  - a pixel presented in the same cycle as commit uses the old active set;
  - a pixel in the following cycle uses the new set.
- Mode: invert is sampled with its own pixel, so it may change every cycle.
- Read-back:
  - thr_rdata reflects shadow one cycle after thr_addr is presented;
  - a write at edge n to the same address is visible in thr_rdata after edge n+1, not n.
- Reset mid-stream:
  - in-flight pixels are discarded;
  - out_valid is 0 from reset assertion until 2 cycles after the first valid pixel following deassertion;
  - thresholds revert to THRESH_INIT and any uncommitted shadow writes are lost.

## Test plan
- **Defaults.** Defaults, invert=0, g = 0, 700, 701, 1300, 1301, 2047 back-to-back → level = 1, 1, 2, 2, 3, 3 on 6 consecutive out_valid cycles starting 2 cycles after the first pixel.
- **Invert.** Same g sequence with invert=1 → level = 3, 3, 2, 2, 1, 1; alternating invert per pixel gives per-pixel results.
- **Shadow isolation.** Write shadow[0]=100 with no commit, then g=500 → level 1. Assert commit, then g=500 the next cycle → level 2. g=500 in the commit cycle itself → level 1.
- **Write during commit.** Write shadow[1]=200 in the same cycle as commit → active[1] stays 1300. A second commit → g=300 gives level 3. thr_rdata at addr 1 reads 200.
- **Out-of-range address.** thr_we with thr_addr=2 (NUM_THRESH=2) → no threshold changes; thr_rdata=0 at addr 2.
- **Reset mid-stream.** Assert reset during a stream of 4 valid pixels after shadow[0]=100 was committed → out_valid=0 and level=0 immediately. After release, g=500 → level 1, showing THRESH_INIT was restored.

Source files
------------

// File: rtl/halftone_level_quantizer_if.sv
// Pixel, level and threshold-programming bus for the halftone level quantizer.
interface halftone_level_quantizer_if #(
    parameter int IN_W = 11,
    parameter int LW   = 2,
    parameter int AW   = 3
);
    logic            in_valid;
    logic [IN_W-1:0] g;
    logic            invert;
    logic            out_valid;
    logic [LW-1:0]   level;
    logic            thr_we;
    logic [AW-1:0]   thr_addr;
    logic [IN_W-1:0] thr_wdata;
    logic [IN_W-1:0] thr_rdata;
    logic            commit;

    modport master (
        output in_valid, g, invert, thr_we, thr_addr, thr_wdata, commit,
        input  out_valid, level, thr_rdata
    );

    modport slave (
        input  in_valid, g, invert, thr_we, thr_addr, thr_wdata, commit,
        output out_valid, level, thr_rdata
    );
endinterface

// File: rtl/halftone_level_quantizer.sv
// Two-stage grey-level quantizer: level = MIN_LEVEL + number of active
// thresholds strictly below g (or its mirror when invert is set).
// Thresholds are double-buffered so a frame only ever sees one set.
module halftone_level_quantizer #(
    parameter int IN_W       = 11,
    parameter int NUM_THRESH = 2,
    parameter int LW         = 2,
    parameter int MIN_LEVEL  = 1,
    parameter int AW         = 3,
    parameter logic [NUM_THRESH*IN_W-1:0] THRESH_INIT = {11'd1300, 11'd700}
) (
    input logic                    clk,
    input logic                    reset,
    halftone_level_quantizer_if.slave bus
);

    logic [NUM_THRESH-1:0][IN_W-1:0] shadow;
    logic [NUM_THRESH-1:0][IN_W-1:0] active;
    logic [IN_W-1:0]                 rd_mux;
    logic [IN_W-1:0]                 rdata_q;

    logic [NUM_THRESH-1:0] gt_n;
    logic [NUM_THRESH-1:0] gt1;
    logic                  inv1;
    logic [1:0]            vld_pipe;   // [0] = stage 1, [1] = output stage
    logic [LW-1:0]         cnt;
    logic [LW-1:0]         lvl_n;
    logic [LW-1:0]         level_q;

    // Read-back mux; addresses past the last threshold read as zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_THRESH; k++)
            if (bus.thr_addr == AW'(k)) rd_mux = shadow[k];
    end

    // Shadow writes, commit copy and registered read-back. Commit copies the
    // pre-edge shadow, so a same-cycle write waits for the next commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= THRESH_INIT;
            active  <= THRESH_INIT;
            rdata_q <= '0;
        end else begin
            for (int k = 0; k < NUM_THRESH; k++)
                if (bus.thr_we && bus.thr_addr == AW'(k)) shadow[k] <= bus.thr_wdata;
            if (bus.commit) active <= shadow;
            rdata_q <= rd_mux;
        end
    end

    // One strict unsigned compare per active threshold.
    always_comb begin
        gt_n = '0;
        for (int k = 0; k < NUM_THRESH; k++)
            gt_n[k] = bus.g > active[k];
    end

    // Stage 1: capture compare vector and mode alongside the pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe[0] <= 1'b0;
            gt1         <= '0;
            inv1        <= 1'b0;
        end else begin
            vld_pipe[0] <= bus.in_valid;
            gt1         <= gt_n;
            inv1        <= bus.invert;
        end
    end

    // Popcount of the stage-1 compares, then map to a level at LW bits.
    always_comb begin
        cnt = '0;
        for (int k = 0; k < NUM_THRESH; k++)
            cnt = cnt + LW'(gt1[k]);
        lvl_n = inv1 ? (LW'(MIN_LEVEL + NUM_THRESH) - cnt)
                     : (LW'(MIN_LEVEL) + cnt);
    end

    // Stage 2: level updates only for valid pixels and holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe[1] <= 1'b0;
            level_q     <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) level_q <= lvl_n;
        end
    end

    assign bus.out_valid = vld_pipe[1];
    assign bus.level     = level_q;
    assign bus.thr_rdata = rdata_q;

endmodule

// File: tb/tb_halftone_level_quantizer.sv
// Directed bench for halftone_level_quantizer with default parameters
// (thresholds 700 / 1300, MIN_LEVEL 1, levels 1..3).
module tb_halftone_level_quantizer;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    halftone_level_quantizer_if #(.IN_W(11), .LW(2), .AW(3)) bus ();

    halftone_level_quantizer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.g         = '0;
        bus.invert    = 1'b0;
        bus.thr_we    = 1'b0;
        bus.thr_wdata = '0;
        bus.commit    = 1'b0;
    endtask

    task automatic pix(input int gv, input bit inv);
        idle();
        bus.in_valid = 1'b1;
        bus.g        = 11'(gv);
        bus.invert   = inv;
    endtask

    task automatic wr(input int addr, input int val);
        idle();
        bus.thr_we    = 1'b1;
        bus.thr_addr  = 3'(addr);
        bus.thr_wdata = 11'(val);
    endtask

    task automatic rd(input string tag, input int addr, input int exp);
        idle();
        bus.thr_addr = 3'(addr);
        tick();
        chk(tag, int'(bus.thr_rdata), exp);
    endtask

    // Back-to-back pixels; output i appears one tick after pixel i+1 is driven.
    task automatic stream(input string tag, input int n, input int gs[6],
                          input bit invs[6], input int exps[6]);
        for (int i = 0; i <= n; i++) begin
            if (i < n) pix(gs[i], invs[i]);
            else       idle();
            tick();
            if (i >= 1) begin
                chk($sformatf("%s_vld[%0d]", tag, i-1), int'(bus.out_valid), 1);
                chk($sformatf("%s_lvl[%0d]", tag, i-1), int'(bus.level), exps[i-1]);
            end
        end
        tick();
        chk({tag, "_idle_vld"}, int'(bus.out_valid), 0);
        chk({tag, "_hold_lvl"}, int'(bus.level), exps[n-1]);
    endtask

    // Single pixel, then return to idle and check its level.
    task automatic one(input string tag, input int gv, input bit inv, input int exp);
        pix(gv, inv);
        tick();
        idle();
        tick();
        chk({tag, "_vld"}, int'(bus.out_valid), 1);
        chk({tag, "_lvl"}, int'(bus.level), exp);
    endtask

    initial begin
        idle();
        bus.thr_addr = '0;
        reset = 1'b1;
        #2;
        chk("rst_vld", int'(bus.out_valid), 0);
        chk("rst_lvl", int'(bus.level), 0);
        chk("rst_rdata", int'(bus.thr_rdata), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Defaults, both modes, and per-pixel mode switching.
        stream("dflt", 6, '{0, 700, 701, 1300, 1301, 2047}, '{0, 0, 0, 0, 0, 0},
               '{1, 1, 2, 2, 3, 3});
        stream("inv", 6, '{0, 700, 701, 1300, 1301, 2047}, '{1, 1, 1, 1, 1, 1},
               '{3, 3, 2, 2, 1, 1});
        stream("alt", 4, '{2047, 2047, 0, 0, 0, 0}, '{0, 1, 0, 1, 0, 0},
               '{3, 1, 1, 3, 0, 0});

        rd("rd_init0", 0, 700);
        rd("rd_init1", 1, 1300);

        // Shadow isolation: uncommitted write has no effect.
        wr(0, 100);
        tick();
        rd("rd_shadow0", 0, 100);
        one("iso_nocommit", 500, 0, 1);
        // Pixel in the commit cycle uses the old set, next pixel the new one.
        pix(500, 0);
        bus.commit = 1'b1;
        tick();
        pix(500, 0);
        tick();
        chk("commit_cyc_lvl", int'(bus.level), 1);
        idle();
        tick();
        chk("after_commit_lvl", int'(bus.level), 2);

        // Write in the commit cycle is not copied.
        wr(1, 200);
        bus.commit = 1'b1;
        tick();
        one("wc_old_active1", 300, 0, 2);
        idle();
        bus.commit = 1'b1;
        tick();
        one("wc_second_commit", 300, 0, 3);
        rd("rd_wc1", 1, 200);

        // Out-of-range address is ignored and reads as zero.
        wr(2, 5);
        tick();
        rd("rd_oor2", 2, 0);
        rd("rd_oor_keep0", 0, 100);
        rd("rd_oor_keep1", 1, 200);
        idle();
        bus.commit = 1'b1;
        tick();
        one("oor_level", 300, 0, 3);

        // Reset mid-stream with committed shadow[0]=100, shadow[1]=200.
        pix(500, 0);
        tick();
        pix(500, 0);
        tick();
        chk("mid_vld", int'(bus.out_valid), 1);
        chk("mid_lvl", int'(bus.level), 3);
        pix(500, 0);
        tick();
        pix(500, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_vld", int'(bus.out_valid), 0);
        chk("mid_rst_lvl", int'(bus.level), 0);
        idle();
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_vld", int'(bus.out_valid), 0);
        tick();
        chk("post_rst_vld2", int'(bus.out_valid), 0);
        one("post_rst_init", 500, 0, 1);
        rd("post_rst_rd0", 0, 700);
        rd("post_rst_rd1", 1, 1300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
